// File: rtl/stoch_mul_core_if.sv
// Handshake and operand/result bundle for stoch_mul_core.
// STOCH_BIPOLAR_OUT_EN adds the signed result_s field.
interface stoch_mul_core_if #(
   parameter int PW = 4,
   parameter int CW = 3
);
   logic                 start;
   logic                 mode;
   logic [PW-1:0]        prob_a;
   logic [PW-1:0]        prob_b;
   logic                 busy;
   logic [CW:0]          result;
   logic                 result_valid;
   logic                 sn_out;
`ifdef STOCH_BIPOLAR_OUT_EN
   logic signed [CW+1:0] result_s;
`endif

   modport master (
      output start, mode, prob_a, prob_b,
      input  busy, result, result_valid, sn_out
`ifdef STOCH_BIPOLAR_OUT_EN
      , input result_s
`endif
   );

   modport slave (
      input  start, mode, prob_a, prob_b,
      output busy, result, result_valid, sn_out
`ifdef STOCH_BIPOLAR_OUT_EN
      , output result_s
`endif
   );
endinterface

// File: rtl/stoch_mul_core.sv
// Stochastic multiplier: two LFSR-driven comparators, AND/XNOR product gate and a
// windowed up-counter. Define STOCH_BIPOLAR_OUT_EN to add the signed result_s output.
module stoch_mul_core #(
   parameter int          PW     = 4,
   parameter int          CW     = 3,
   parameter logic [30:0] SEED_A = 31'd1,
   parameter logic [30:0] SEED_B = 31'd2
) (
   input logic              clk,
   input logic              rst_n,
   stoch_mul_core_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, FILL, COUNT, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] phase_q, phase_d;
   logic [CW:0]   count_q, count_d;
   logic [CW:0]   result_q, result_d;
   logic [PW-1:0] opa_q, opa_d, opb_q, opb_d;
   logic          mode_q, mode_d;
   logic [30:0]   lfsr_a_q, lfsr_b_q;
   logic          sn_a_q, sn_b_q, sn_q;

`ifdef STOCH_BIPOLAR_OUT_EN
   localparam logic [CW+1:0] N_EXT = (CW+2)'(1 << CW);
   logic signed [CW+1:0] result_s_q, result_s_d;
   assign result_s_d     = $signed({result_d, 1'b0} - N_EXT);
   assign bus.result_s   = result_s_q;
`endif

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d  = state_q;
      phase_d  = phase_q;
      count_d  = count_q;
      result_d = result_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      mode_d   = mode_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FILL;
               phase_d = '0;
               count_d = '0;
               opa_d   = bus.prob_a;
               opb_d   = bus.prob_b;
               mode_d  = bus.mode;
            end
         end
         FILL: begin
            // Two cycles let the comparator and gate stages settle on the new operands.
            if (phase_q == CW'(1)) begin
               state_d = COUNT;
               phase_d = '0;
            end else begin
               phase_d = phase_q + CW'(1);
            end
         end
         COUNT: begin
            count_d = count_q + (CW+1)'(sn_q);
            if (phase_q == '1) begin
               state_d  = DONE;
               phase_d  = '0;
               result_d = count_q + (CW+1)'(sn_q);
            end else begin
               phase_d = phase_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      // NOTE: rst_n is asserted high here; non-blocking assignments keep every register sampling pre-edge values.
      if (rst_n) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         count_q    <= '0;
         result_q   <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         mode_q     <= 1'b0;
         lfsr_a_q   <= SEED_A;
         lfsr_b_q   <= SEED_B;
         sn_a_q     <= 1'b0;
         sn_b_q     <= 1'b0;
         sn_q       <= 1'b0;
`ifdef STOCH_BIPOLAR_OUT_EN
         result_s_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         count_q    <= count_d;
         result_q   <= result_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         mode_q     <= mode_d;
         // x^31 + x^28 + 1, shifting in every state
         lfsr_a_q   <= {lfsr_a_q[29:0], lfsr_a_q[27] ^ lfsr_a_q[30]};
         lfsr_b_q   <= {lfsr_b_q[29:0], lfsr_b_q[27] ^ lfsr_b_q[30]};
         sn_a_q     <= (lfsr_a_q[PW-1:0] < opa_q);
         sn_b_q     <= (lfsr_b_q[PW-1:0] < opb_q);
         sn_q       <= mode_q ? ~(sn_a_q ^ sn_b_q) : (sn_a_q & sn_b_q);
`ifdef STOCH_BIPOLAR_OUT_EN
         if (state_q == COUNT && state_d == DONE) result_s_q <= result_s_d;
`endif
      end
   end

   assign bus.busy         = (state_q != IDLE);
   assign bus.result_valid = (state_q == DONE);
   assign bus.result       = result_q;
   assign bus.sn_out       = sn_q;
endmodule

// File: tb/tb_stoch_mul_core.sv
// Directed bench for stoch_mul_core: N=8 instance for handshake/edge cases and an
// N=32 instance for back-to-back runs, both checked against an LFSR replay model.
module tb_stoch_mul_core;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   stoch_mul_core_if #(.PW(4), .CW(3)) bus3 ();
   stoch_mul_core_if #(.PW(4), .CW(5)) bus5 ();

   stoch_mul_core #(.PW(4), .CW(3), .SEED_A(31'd1), .SEED_B(31'd2)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   stoch_mul_core #(.PW(4), .CW(5), .SEED_A(31'd1), .SEED_B(31'd2)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [30:0] lfsr_step(input logic [30:0] x);
      return {x[29:0], x[27] ^ x[30]};
   endfunction

   // Reference LFSRs, reset and stepped exactly like the hardware ones.
   logic [30:0] m_a, m_b;
   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         m_a <= 31'd1;
         m_b <= 31'd2;
      end else begin
         m_a <= lfsr_step(m_a);
         m_b <= lfsr_step(m_b);
      end
   end

   // a0/b0 are the LFSR values present in the cycle right after the accepting edge.
   function automatic int model_count(input logic [30:0] a0, input logic [30:0] b0,
                                      input logic [3:0] pa, input logic [3:0] pb,
                                      input logic m, input int n);
      logic [30:0] a;
      logic [30:0] b;
      logic        sa;
      logic        sb;
      int          s;
      a = a0;
      b = b0;
      s = 0;
      for (int k = 0; k < n; k++) begin
         sa = (a[3:0] < pa);
         sb = (b[3:0] < pb);
         if (m ? (sa == sb) : (sa && sb)) s++;
         a = lfsr_step(a);
         b = lfsr_step(b);
      end
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One N=8 run; samples c=0..12 after the accepting edge. poke re-requests with other operands while busy.
   task automatic run3(input logic [3:0] pa, input logic [3:0] pb, input logic m, input bit poke,
                       output int exp_res, output int got_res, output int got_rs,
                       output int nvalid, output int nbusy, output int valid_at);
      bus3.prob_a = pa;
      bus3.prob_b = pb;
      bus3.mode   = m;
      bus3.start  = 1'b1;
      step();
      bus3.start = 1'b0;
      exp_res  = model_count(m_a, m_b, pa, pb, m, 8);
      got_res  = -1;
      got_rs   = 0;
      nvalid   = 0;
      nbusy    = 0;
      valid_at = -1;
      for (int c = 0; c <= 12; c++) begin
         if (bus3.busy) nbusy++;
         if (bus3.result_valid) begin
            nvalid++;
            valid_at = c;
            got_res  = int'(bus3.result);
`ifdef STOCH_BIPOLAR_OUT_EN
            got_rs   = int'(bus3.result_s);
`endif
         end
         if (poke && c >= 1 && c <= 10) begin
            bus3.start  = 1'b1;
            bus3.prob_a = ~pa;
            bus3.prob_b = ~pb;
            bus3.mode   = ~m;
         end else begin
            bus3.start  = 1'b0;
            bus3.prob_a = pa;
            bus3.prob_b = pb;
            bus3.mode   = m;
         end
         step();
      end
   endtask

   initial begin
      int exp_res, got_res, got_rs, nvalid, nbusy, valid_at;
      int exp5;
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      bus3.start = 1'b0; bus3.mode = 1'b0; bus3.prob_a = '0; bus3.prob_b = '0;
      bus5.start = 1'b0; bus5.mode = 1'b0; bus5.prob_a = '0; bus5.prob_b = '0;

      #3;
      check("reset_busy",   32'(bus3.busy), 0);
      check("reset_result", 32'(bus3.result), 0);
      check("reset_valid",  32'(bus3.result_valid), 0);
      check("reset_sn_out", 32'(bus3.sn_out), 0);
      step();
      step();
      rst_n = 1'b0;
      step();

      // Unipolar 0 x 15: empty stream, timing of valid and busy.
      run3(4'd0, 4'd15, 1'b0, 1'b0, exp_res, got_res, got_rs, nvalid, nbusy, valid_at);
      check("uni_0x15_result",   got_res, 0);
      check("uni_0x15_valid_at", valid_at, 10);
      check("uni_0x15_busy_len", nbusy, 11);
      check("uni_0x15_nvalid",   nvalid, 1);

      // Bipolar 0 x 0: XNOR of two all-zero streams saturates at N without wrapping.
      run3(4'd0, 4'd0, 1'b1, 1'b0, exp_res, got_res, got_rs, nvalid, nbusy, valid_at);
      check("bip_0x0_result", got_res, 8);
`ifdef STOCH_BIPOLAR_OUT_EN
      check("bip_0x0_result_s", got_rs, 8);
`endif

      // Bipolar 0 x 15: ones only where lfsr_b[3:0]==15; exact value from the replay model.
      run3(4'd0, 4'd15, 1'b1, 1'b0, exp_res, got_res, got_rs, nvalid, nbusy, valid_at);
      check("bip_0x15_result", got_res, exp_res);

      run3(4'd9, 4'd6, 1'b0, 1'b0, exp_res, got_res, got_rs, nvalid, nbusy, valid_at);
      check("uni_9x6_result", got_res, exp_res);

      run3(4'd12, 4'd10, 1'b1, 1'b0, exp_res, got_res, got_rs, nvalid, nbusy, valid_at);
      check("bip_12x10_result", got_res, exp_res);

      // Requests while busy, with different operands, must not disturb the run.
      run3(4'd0, 4'd0, 1'b1, 1'b1, exp_res, got_res, got_rs, nvalid, nbusy, valid_at);
      check("poke_result",   got_res, 8);
      check("poke_nvalid",   nvalid, 1);
      check("poke_busy_len", nbusy, 11);
      check("poke_idle",     32'(bus3.busy), 0);

      // Abort mid-COUNT with reset; held result of 8 must clear at once.
      bus3.prob_a = 4'd0; bus3.prob_b = 4'd0; bus3.mode = 1'b1; bus3.start = 1'b1;
      step();
      bus3.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("abort_held_result", 32'(bus3.result), 8);
      rst_n = 1'b1;
      #2;
      check("abort_busy",   32'(bus3.busy), 0);
      check("abort_result", 32'(bus3.result), 0);
      check("abort_valid",  32'(bus3.result_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      step();
      run3(4'd0, 4'd0, 1'b1, 1'b0, exp_res, got_res, got_rs, nvalid, nbusy, valid_at);
      check("after_abort_result",   got_res, 8);
      check("after_abort_valid_at", valid_at, 10);

      // Back-to-back on N=32: start held, period 36, each window checked against the model.
      bus5.prob_a = 4'd8; bus5.prob_b = 4'd8; bus5.mode = 1'b0; bus5.start = 1'b1;
      step();
      for (int r = 0; r < 3; r++) begin
         exp5 = model_count(m_a, m_b, 4'd8, 4'd8, 1'b0, 32);
         for (int c = 1; c <= 33; c++) step();
         check($sformatf("b2b%0d_valid_early", r), 32'(bus5.result_valid), 0);
         step();
         check($sformatf("b2b%0d_valid", r), 32'(bus5.result_valid), 1);
         check($sformatf("b2b%0d_result", r), 32'(bus5.result), exp5);
         step();
         if (r == 2) bus5.start = 1'b0;
         step();
         check($sformatf("b2b%0d_restart", r), 32'(bus5.busy), (r < 2) ? 1 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
